// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I-side/D-side unified memory arbiter.
package mem_arb_pkg;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } grant_src_t;

  // Single requester wins outright; on conflict the side not served last wins.
  function automatic grant_src_t pick_src(logic if_req, logic d_req, grant_src_t last);
    if (if_req && d_req) return (last == SRC_I) ? SRC_D : SRC_I;
    return d_req ? SRC_D : SRC_I;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Grant-cycle watchdog: counts cycles of an open grant and flags the TIMEOUT-th one.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Counter reads k-1 during the k-th grant cycle, so LAST marks the TIMEOUT-th cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data request ports onto one external memory port.
// Optional grant watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  output logic              IF_Ack,
  output logic [DATA_W-1:0] IF_RData,
  input  logic              D_Req,
  input  logic              D_Write,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_WData,
  input  logic [BE_W-1:0]   D_BE,
  output logic              D_Ack,
  output logic [DATA_W-1:0] D_RData,
  output logic              Mem_Req,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic [BE_W-1:0]   Mem_BE,
  input  logic              Mem_Ack,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Bus_Err
);

  arb_state_t state;
  grant_src_t last_grant;
  grant_src_t start_src;
  logic       start;
  logic       granted;
  logic       expired;
  logic       xact_done;
  logic       abort;

  assign granted   = (state != ARB_IDLE);
  assign xact_done = granted && (Mem_Ack || expired);
  assign abort     = granted && expired && !Mem_Ack;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (start),
    .run    (granted),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  // A completing grant hands straight over to a waiting opposite side, avoiding an idle gap.
  always_comb begin
    start     = 1'b0;
    start_src = SRC_I;
    case (state)
      ARB_IDLE: begin
        start     = IF_Req || D_Req;
        start_src = pick_src(IF_Req, D_Req, last_grant);
      end
      ARB_GRANT_I: begin
        start     = xact_done && D_Req;
        start_src = SRC_D;
      end
      ARB_GRANT_D: begin
        start     = xact_done && IF_Req;
        start_src = SRC_I;
      end
      default: begin
        start     = 1'b0;
        start_src = SRC_I;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ARB_IDLE;
      last_grant <= SRC_I;
      Mem_Write  <= 1'b0;
      Mem_Addr   <= '0;
      Mem_WData  <= '0;
      Mem_BE     <= '0;
    end else begin
      if (xact_done) begin
        last_grant <= (state == ARB_GRANT_D) ? SRC_D : SRC_I;
      end
      if (start) begin
        if (start_src == SRC_D) begin
          state     <= ARB_GRANT_D;
          Mem_Write <= D_Write;
          Mem_Addr  <= D_Addr;
          Mem_WData <= D_WData;
          Mem_BE    <= D_BE;
        end else begin
          state     <= ARB_GRANT_I;
          Mem_Write <= 1'b0;
          Mem_Addr  <= IF_Addr;
          Mem_WData <= '0;
          Mem_BE    <= {BE_W{1'b1}};
        end
      end else if (xact_done) begin
        state <= ARB_IDLE;
      end
    end
  end

  // Acks and read data are relayed combinationally from the memory side.
  assign Mem_Req  = granted;
  assign IF_Ack   = (state == ARB_GRANT_I) && (Mem_Ack || expired);
  assign D_Ack    = (state == ARB_GRANT_D) && (Mem_Ack || expired);
  assign Bus_Err  = abort;
  assign IF_RData = abort ? '0 : Mem_RData;
  assign D_RData  = abort ? '0 : Mem_RData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, behavioural memory responder.
// The timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_Req = 1'b0;
  logic [31:0] IF_Addr = '0;
  logic        IF_Ack;
  logic [31:0] IF_RData;
  logic        D_Req = 1'b0;
  logic        D_Write = 1'b0;
  logic [31:0] D_Addr = '0;
  logic [31:0] D_WData = '0;
  logic [3:0]  D_BE = '0;
  logic        D_Ack;
  logic [31:0] D_RData;
  logic        Mem_Req;
  logic        Mem_Write;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [3:0]  Mem_BE;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_RData = '0;
  logic        Bus_Err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ack(IF_Ack), .IF_RData(IF_RData),
    .D_Req(D_Req), .D_Write(D_Write), .D_Addr(D_Addr), .D_WData(D_WData), .D_BE(D_BE),
    .D_Ack(D_Ack), .D_RData(D_RData),
    .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_BE(Mem_BE), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData), .Bus_Err(Bus_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          side;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Responder controls, written only by the main stimulus thread.
  bit   mem_en = 1'b1;
  int   ack_delay = 1;
  bit   stray_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit side, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] rdata, input logic err);
    exp_t e;
    e.side = side; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.be = be; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // Memory model: acks after ack_delay wait cycles of Mem_Req, data from address.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (Mem_Ack) wait_cnt = 0;
      Mem_Ack = 1'b0;
      if (stray_ack) begin
        Mem_Ack   = 1'b1;
        Mem_RData = 32'h5555_AAAA;
      end else if (Mem_Req && mem_en) begin
        if (wait_cnt >= ack_delay) begin
          Mem_Ack   = 1'b1;
          Mem_RData = (Mem_Addr == 32'h100) ? 32'hDEAD_BEEF : {Mem_Addr[15:0], 16'hCAFE};
        end else begin
          wait_cnt++;
        end
      end else if (!Mem_Req) begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every ack pops one expected transaction and checks the memory-side view.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (IF_Ack || D_Ack) begin
        chk("dual_ack", 32'(IF_Ack && D_Ack), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, D_Ack, IF_Ack}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_side", 32'(D_Ack), 32'(e.side));
          chk("mem_req_at_ack", 32'(Mem_Req), 32'd1);
          chk("mem_addr", Mem_Addr, e.addr);
          chk("mem_write", 32'(Mem_Write), 32'(e.wr));
          chk("mem_wdata", Mem_WData, e.wdata);
          chk("mem_be", 32'(Mem_BE), 32'(e.be));
          chk("rdata", D_Ack ? D_RData : IF_RData, e.rdata);
          chk("bus_err", 32'(Bus_Err), 32'(e.err));
        end
      end
    end
  end

  // Runs until each side has seen its ack count, dropping Req the cycle after its last ack.
  task automatic wait_acks(input int n_i, input int n_d, input int budget, output int cycles);
    int gi = 0;
    int gd = 0;
    cycles = 0;
    while ((gi < n_i || gd < n_d) && cycles < budget) begin
      @(negedge CLK);
      if (IF_Ack) gi++;
      if (D_Ack) gd++;
      cycles++;
      if (gi < n_i || gd < n_d) begin
        @(posedge CLK);
        #1;
        if (gi >= n_i) IF_Req = 1'b0;
        if (gd >= n_d) D_Req = 1'b0;
      end
    end
    chk("ack_timeout", 32'((gi >= n_i) && (gd >= n_d)), 32'd1);
    @(posedge CLK);
    #1;
    IF_Req = 1'b0;
    D_Req  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_req", 32'(Mem_Req), 32'd0);
    chk("rst_mem_be", 32'(Mem_BE), 32'd0);
    chk("rst_mem_addr", Mem_Addr, 32'd0);
    chk("rst_acks", {29'd0, Bus_Err, D_Ack, IF_Ack}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // 1: single fetch, memory acks in the second grant cycle
    @(posedge CLK);
    #1;
    ack_delay = 1;
    IF_Addr = 32'h100;
    IF_Req  = 1'b1;
    push(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    @(negedge CLK);
    chk("t1_req_cyc0", 32'(Mem_Req), 32'd0);
    @(negedge CLK);
    chk("t1_req_cyc1", 32'(Mem_Req), 32'd1);
    chk("t1_ack_cyc1", 32'(IF_Ack), 32'd0);
    @(negedge CLK);
    chk("t1_ack_cyc2", 32'(IF_Ack), 32'd1);
    @(posedge CLK);
    #1;
    IF_Req = 1'b0;
    @(negedge CLK);
    chk("t1_idle_after", 32'(Mem_Req), 32'd0);

    // 2: simultaneous requests after reset: D wins, then I with no idle gap
    pulse_reset();
    ack_delay = 0;
    IF_Addr = 32'h200;
    D_Write = 1'b1; D_Addr = 32'h40; D_WData = 32'h1234; D_BE = 4'b0011;
    IF_Req = 1'b1; D_Req = 1'b1;
    push(1'b1, 1'b1, 32'h40, 32'h1234, 4'b0011, 32'h0040_CAFE, 1'b0);
    push(1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h0200_CAFE, 1'b0);
    wait_acks(1, 1, 20, cyc);
    chk("t2_back_to_back", 32'(cyc), 32'd3);

    // 3: both held continuously: D, I, D, I
    @(posedge CLK);
    #1;
    IF_Addr = 32'h300;
    D_Write = 1'b0; D_Addr = 32'h80; D_WData = 32'h9999; D_BE = 4'hC;
    IF_Req = 1'b1; D_Req = 1'b1;
    push(1'b1, 1'b0, 32'h80, 32'h9999, 4'hC, 32'h0080_CAFE, 1'b0);
    push(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0300_CAFE, 1'b0);
    push(1'b1, 1'b0, 32'h80, 32'h9999, 4'hC, 32'h0080_CAFE, 1'b0);
    push(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0300_CAFE, 1'b0);
    wait_acks(2, 2, 30, cyc);
    chk("t3_alternate_cycles", 32'(cyc), 32'd5);

    // 4: reset mid-grant before any ack, then a clean fetch
    @(posedge CLK);
    #1;
    mem_en = 1'b0;
    D_Write = 1'b1; D_Addr = 32'h44; D_WData = 32'h7777; D_BE = 4'hF;
    D_Req = 1'b1;
    repeat (2) @(negedge CLK);
    chk("t4_granted", 32'(Mem_Req), 32'd1);
    chk("t4_grant_addr", Mem_Addr, 32'h44);
    #2;
    RST = 1'b1;
    #1;
    chk("t4_rst_req", 32'(Mem_Req), 32'd0);
    chk("t4_rst_wr_be", {27'd0, Mem_Write, Mem_BE}, 32'd0);
    chk("t4_rst_addr", Mem_Addr, 32'd0);
    chk("t4_rst_dack", 32'(D_Ack), 32'd0);
    D_Req = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    mem_en = 1'b1;
    ack_delay = 1;
    IF_Addr = 32'h104;
    IF_Req = 1'b1;
    push(1'b0, 1'b0, 32'h104, 32'h0, 4'hF, 32'h0104_CAFE, 1'b0);
    wait_acks(1, 0, 20, cyc);

`ifdef MEM_ARB_TIMEOUT_EN
    // 5: memory never answers: abort in the 8th grant cycle
    begin
      int gcyc = 0;
      bit seen = 1'b0;
      @(posedge CLK);
      #1;
      mem_en = 1'b0;
      D_Write = 1'b0; D_Addr = 32'h48; D_WData = 32'h0; D_BE = 4'hF;
      D_Req = 1'b1;
      push(1'b1, 1'b0, 32'h48, 32'h0, 4'hF, 32'h0, 1'b1);
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge CLK);
        if (Mem_Req) gcyc++;
        if (D_Ack) seen = 1'b1;
      end
      chk("t5_abort_cycle", 32'(gcyc), 32'd8);
      @(posedge CLK);
      #1;
      D_Req = 1'b0;
      @(negedge CLK);
      chk("t5_idle_after", 32'(Mem_Req), 32'd0);
      mem_en = 1'b1;
    end
`endif

    // 6: stray Mem_Ack while idle
    @(posedge CLK);
    #1;
    stray_ack = 1'b1;
    @(negedge CLK);
    chk("t6_stray_acks", {30'd0, D_Ack, IF_Ack}, 32'd0);
    chk("t6_stray_req", 32'(Mem_Req), 32'd0);
    @(posedge CLK);
    #1;
    stray_ack = 1'b0;
    @(negedge CLK);
    chk("t6_still_idle", 32'(Mem_Req), 32'd0);

    repeat (3) @(posedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
